// File: rtl/regfile_2r1w_sb.sv
// Register file with two read ports, one byte-enabled write port,
// a busy scoreboard and a sequential clear-on-reset init engine.
// Ports: clk, rst_n (sync, active-low); i_wr_* write port;
// i_lock_* busy set; i_rdN_addr -> o_rdN_data/o_rdN_busy; o_ready.
module regfile_2r1w_sb #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int READ_LATENCY = 0,
  parameter int BYPASS       = 1,
  parameter int ZERO_REG     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be,
  input  logic                    i_lock_en,
  input  logic [ADDR_WIDTH-1:0]   i_lock_addr,
  input  logic [ADDR_WIDTH-1:0]   i_rd0_addr,
  output logic [DATA_WIDTH-1:0]   o_rd0_data,
  output logic                    o_rd0_busy,
  input  logic [ADDR_WIDTH-1:0]   i_rd1_addr,
  output logic [DATA_WIDTH-1:0]   o_rd1_data,
  output logic                    o_rd1_busy,
  output logic                    o_ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;

  logic                  run;
  logic                  wr_ok;
  logic                  lk_ok;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] wmerged;
  logic [ADDR_WIDTH-1:0] ra [2];
  logic [DATA_WIDTH-1:0] rv [2];

  assign run     = (state_q == S_RUN);
  assign o_ready = run;

  // Entry 0 is immune to writes and locks when hardwired to zero.
  assign wr_ok = run && i_wr_en &&
                 !((ZERO_REG != 0) && (i_wr_addr == '0));
  assign lk_ok = run && i_lock_en &&
                 !((ZERO_REG != 0) && (i_lock_addr == '0));

  always_comb begin
    wmask = '0;
    for (int k = 0; k < NB; k++) begin
      wmask[8*k +: 8] = {8{i_wr_be[k]}};
    end
  end

  assign wmerged = (mem_q[i_wr_addr] & ~wmask) |
                   (i_wr_data & wmask);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The array itself is not reset; the init engine clears it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_ok) begin
        mem_q[i_wr_addr] <= wmerged;
      end
    end
  end

  // Lock is applied after clear so it wins on a same-address collision.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[i_wr_addr] = 1'b0;
    end
    if (lk_ok) begin
      busy_d[i_lock_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign ra[0] = i_rd0_addr;
  assign ra[1] = i_rd1_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rv[p] = mem_q[ra[p]];
      if ((BYPASS != 0) && wr_ok && (i_wr_addr == ra[p])) begin
        rv[p] = (rv[p] & ~wmask) | (i_wr_data & wmask);
      end
      if (!run || ((ZERO_REG != 0) && (ra[p] == '0))) begin
        rv[p] = '0;
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb
      assign o_rd0_data = rv[0];
      assign o_rd1_data = rv[1];
      assign o_rd0_busy = run & busy_q[i_rd0_addr];
      assign o_rd1_busy = run & busy_q[i_rd1_addr];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd0_q, rd1_q;
      logic                  rb0_q, rb1_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd0_q <= '0;
          rd1_q <= '0;
          rb0_q <= 1'b0;
          rb1_q <= 1'b0;
        end else begin
          rd0_q <= rv[0];
          rd1_q <= rv[1];
          rb0_q <= run & busy_d[i_rd0_addr];
          rb1_q <= run & busy_d[i_rd1_addr];
        end
      end
      assign o_rd0_data = rd0_q;
      assign o_rd1_data = rd1_q;
      assign o_rd0_busy = rb0_q;
      assign o_rd1_busy = rb1_q;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Scoreboard bench for regfile_2r1w_sb (default parameters).
// Driver pushes model expectations; a negedge monitor compares.
module tb_regfile_2r1w_sb;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int D  = 16;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_be;
  logic          lock_en;
  logic [AW-1:0] lock_addr;
  logic [AW-1:0] rd0_addr;
  logic [DW-1:0] rd0_data;
  logic          rd0_busy;
  logic [AW-1:0] rd1_addr;
  logic [DW-1:0] rd1_data;
  logic          rd1_busy;
  logic          ready;

  regfile_2r1w_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_wr_be    (wr_be),
    .i_lock_en  (lock_en),
    .i_lock_addr(lock_addr),
    .i_rd0_addr (rd0_addr),
    .o_rd0_data (rd0_data),
    .o_rd0_busy (rd0_busy),
    .i_rd1_addr (rd1_addr),
    .o_rd1_data (rd1_data),
    .o_rd1_busy (rd1_busy),
    .o_ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          b0;
    logic          b1;
    logic          rdy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] m_mem [D];
  bit            m_busy [D];
  int            m_edges = 0;
  bit            m_known = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o,
                                          input logic [DW-1:0] n,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (m_edges < D || a == 0) return '0;
    v = m_mem[a];
    if (wr_en && wr_addr == a) v = merge(v, wr_data, wr_be);
    return v;
  endfunction

  function automatic logic m_bsy(input logic [AW-1:0] a);
    if (m_edges < D || a == 0) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model then steps across the next edge.
  task automatic cyc(input bit rst, input bit we,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [3:0] be, input bit lk,
                     input logic [AW-1:0] la,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    wr_be = be; lock_en = lk; lock_addr = la;
    rd0_addr = a0; rd1_addr = a1;
    if (m_known) begin
      e.d0  = m_read(a0);
      e.d1  = m_read(a1);
      e.b0  = m_bsy(a0);
      e.b1  = m_bsy(a1);
      e.rdy = (m_edges >= D);
      q.push_back(e);
    end
    if (!rst) begin
      m_edges = 0;
      m_known = 1;
      for (int i = 0; i < D; i++) m_busy[i] = 0;
    end else if (m_known) begin
      if (m_edges >= D) begin
        if (we && wa != 0) begin
          m_mem[wa]  = merge(m_mem[wa], wd, be);
          m_busy[wa] = 0;
        end
        if (lk && la != 0) m_busy[la] = 1;
      end else begin
        m_edges++;
        if (m_edges == D) begin
          for (int i = 0; i < D; i++) m_mem[i] = '0;
        end
      end
    end
  endtask

  task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    cyc(1, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_rd0_data", rd0_data, e.d0);
      chk("sb_rd1_data", rd1_data, e.d1);
      chk("sb_rd0_busy", {31'b0, rd0_busy}, {31'b0, e.b0});
      chk("sb_rd1_busy", {31'b0, rd1_busy}, {31'b0, e.b1});
      chk("sb_ready", {31'b0, ready}, {31'b0, e.rdy});
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
    lock_en = 0; lock_addr = 0; rd0_addr = 0; rd1_addr = 0;
    for (int i = 0; i < D; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 0;
    end

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // First rst=1 call still sees the reset edge; call n => n-1 edges.
    for (int n = 1; n <= 17; n++) begin
      idle(5, 9);
      #1;
      if (n == 16) chk("ready_low_15", {31'b0, ready}, 32'd0);
      if (n == 17) chk("ready_high_16", {31'b0, ready}, 32'd1);
    end

    cyc(1, 1, 9, 32'hDEAD_BEEF, 4'hF, 0, 0, 9, 9);
    cyc(1, 1, 5, 32'h1122_3344, 4'hF, 0, 0, 5, 9);
    cyc(1, 1, 5, 32'hAABB_CCDD, 4'b0101, 0, 0, 5, 5);
    idle(5, 9);
    #1;
    chk("be_merge", rd0_data, 32'h11BB_33DD);
    chk("seed_9", rd1_data, 32'hDEAD_BEEF);

    cyc(1, 1, 3, 32'h1234_5600, 4'hF, 0, 0, 0, 0);
    cyc(1, 1, 3, 32'h0000_00FF, 4'b0001, 0, 0, 3, 3);
    #1;
    chk("bypass_rd0", rd0_data, 32'h1234_56FF);
    chk("bypass_rd1", rd1_data, 32'h1234_56FF);

    cyc(1, 0, 0, 0, 0, 1, 7, 0, 7);
    idle(0, 7);
    #1;
    chk("lock_busy", {31'b0, rd1_busy}, 32'd1);
    cyc(1, 1, 7, 32'h0000_0777, 4'hF, 0, 0, 0, 7);
    idle(0, 7);
    #1;
    chk("write_clears", {31'b0, rd1_busy}, 32'd0);
    cyc(1, 1, 7, 32'hCAFE_0007, 4'hF, 1, 7, 0, 7);
    idle(0, 7);
    #1;
    chk("lock_wins_busy", {31'b0, rd1_busy}, 32'd1);
    chk("lock_wins_data", rd1_data, 32'hCAFE_0007);

    cyc(1, 1, 0, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0);
    #1;
    chk("zero_bypass", rd0_data, 32'd0);
    idle(0, 0);
    #1;
    chk("zero_data", rd0_data, 32'd0);
    chk("zero_busy", {31'b0, rd0_busy}, 32'd0);

    // Reset in RUN, then again at init cycle 8 with a write attempt.
    cyc(0, 0, 0, 0, 0, 0, 0, 9, 5);
    for (int n = 0; n < 8; n++) begin
      cyc(1, 1, 5, 32'h5555_5555, 4'hF, 1, 5, 9, 5);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 9, 5);
    for (int n = 1; n <= 17; n++) begin
      if (n == 4) cyc(1, 1, 6, 32'h6666_6666, 4'hF, 1, 6, 9, 6);
      else idle(9, 5);
      #1;
      if (n == 16) chk("rst_ready_low", {31'b0, ready}, 32'd0);
      if (n == 17) chk("rst_ready_high", {31'b0, ready}, 32'd1);
    end
    idle(9, 6);
    #1;
    chk("seed_cleared", rd0_data, 32'd0);
    chk("init_write_gone", rd1_data, 32'd0);
    chk("init_lock_gone", {31'b0, rd1_busy}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] wa, a0, a1;
      wa = AW'($urandom_range(0, D - 1));
      a0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, D - 1));
      a1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, D - 1));
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 1) == 1), wa, $urandom,
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, D - 1)),
          a0, a1);
    end

    idle(0, 0);
    idle(0, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
